// File: rtl/atto_pkg.sv
// Shared definitions for the PE network interface.
// Holds the flit geometry, the field offsets inside a flit, the flit
// payload struct, a flit packing helper and the transmit FSM encoding.
package atto_pkg;

   localparam int unsigned PKT_W       = 48;
   localparam int unsigned PAYLOAD_W   = 40;
   localparam int unsigned COORD_W     = 4;

   localparam int unsigned PAYLOAD_LSB = 0;
   localparam int unsigned Y_LSB       = PAYLOAD_W;
   localparam int unsigned X_LSB       = PAYLOAD_W + COORD_W;

   // Flit as seen on the router PE inport: {x, y, payload}.
   typedef struct packed {
      logic [COORD_W-1:0]   x;
      logic [COORD_W-1:0]   y;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   typedef enum logic [0:0] {
      TX_IDLE     = 1'b0,
      TX_WAIT_ACK = 1'b1
   } tx_state_e;

   // Places the destination and payload at their offsets in a flit.
   function automatic flit_t pack_flit(input logic [COORD_W-1:0]   x,
                                       input logic [COORD_W-1:0]   y,
                                       input logic [PAYLOAD_W-1:0] payload);
      logic [PKT_W-1:0] f;
      f = '0;
      f[X_LSB +: COORD_W]           = x;
      f[Y_LSB +: COORD_W]           = y;
      f[PAYLOAD_LSB +: PAYLOAD_W]   = payload;
      return flit_t'(f);
   endfunction

endpackage

// File: rtl/pe_rx_fifo.sv
// Receive FIFO between the router PE outport and the processing element.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, pop     push request (new flit), pop request (PE consumes head)
//   din           data to push
//   head          registered FIFO head (0 when empty)
//   valid         registered, head holds a queued entry
//   full          registered, all DEPTH entries occupied
//   overflow      sticky, a push was dropped because the FIFO was full
module pe_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic             full,
   output logic             overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [CW-1:0]    count_q;

   logic             do_pop;
   logic             do_push;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    remain;
   logic [AW-1:0]    rd_ptr_next;
   logic [WIDTH-1:0] head_next;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   always_comb begin
      do_pop      = pop && (count_q != '0);
      do_push     = push && ((count_q != CW'(DEPTH)) || do_pop);
      count_next  = count_q + CW'(do_push) - CW'(do_pop);
      remain      = count_q - CW'(do_pop);
      rd_ptr_next = rd_ptr_q + AW'(do_pop);
      head_next   = '0;
      if (count_next == '0) begin
         head_next = '0;
      end else if (remain == '0) begin
         // Nothing older left: the incoming word becomes the head.
         head_next = din;
      end else begin
         head_next = mem[rd_ptr_next];
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= din;
      end
   end

   // Pointers, occupancy and registered status.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head     <= '0;
         valid    <= 1'b0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_next;
         wr_ptr_q <= wr_ptr_q + AW'(do_push);
         count_q  <= count_next;
         head     <= head_next;
         valid    <= (count_next != '0);
         full     <= (count_next == CW'(DEPTH));
         overflow <= overflow | (push & ~do_push);
      end
   end

endmodule

// File: rtl/pe_network_interface.sv
// PE-side endpoint of the router PE port.
// Transmit: packs {x, y, payload} into a flit, signals it by toggling the
// differential pair and waits for the router ack, re-toggling on timeout.
// Receive: detects toggles on the router outport pair and queues payloads.
// Ports:
//   clka, rsta                     clock, synchronous active-high reset
//   tx_valid_din, tx_*_din         packet offered by the PE
//   tx_ready_dout                  interface idle, packet can be accepted
//   channel_dout, diff_pair_dout   flit and toggle {t, ~t} to the router
//   r2pe_ack_din                   router accepted the flit (pulse)
//   channel_din, diff_pair_din     payload and toggle from the router
//   rx_valid_dout, rx_payload_dout FIFO head towards the PE
//   rx_ready_din                   PE pops the head
//   rx_overflow_dout               sticky, a received flit was dropped
//   tx_retry_count_dout            saturating retransmission count
module pe_network_interface
   import atto_pkg::*;
#(
   parameter int unsigned RX_DEPTH    = 4,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic                 clka,
   input  logic                 rsta,
   input  logic                 tx_valid_din,
   input  logic [COORD_W-1:0]   tx_x_dest_din,
   input  logic [COORD_W-1:0]   tx_y_dest_din,
   input  logic [PAYLOAD_W-1:0] tx_payload_din,
   output logic                 tx_ready_dout,
   output logic [PKT_W-1:0]     channel_dout,
   output logic [1:0]           diff_pair_dout,
   input  logic                 r2pe_ack_din,
   input  logic [PAYLOAD_W-1:0] channel_din,
   input  logic [1:0]           diff_pair_din,
   output logic                 rx_valid_dout,
   output logic [PAYLOAD_W-1:0] rx_payload_dout,
   input  logic                 rx_ready_din,
   output logic                 rx_overflow_dout,
   output logic [7:0]           tx_retry_count_dout
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT);

   tx_state_e     state_q;
   logic [TW-1:0] timer_q;
   flit_t         channel_q;
   logic [1:0]    diff_q;
   logic [7:0]    retry_q;
   logic          t_rx_q;
   logic          rx_new_c;
   logic          rx_full_unused;

   // Transmit FSM: accept, toggle, wait for ack, re-toggle every ACK_TIMEOUT.
   // An ack always takes priority over a coincident timeout.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q   <= TX_IDLE;
         timer_q   <= '0;
         channel_q <= '0;
         diff_q    <= 2'b01;
         retry_q   <= '0;
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (tx_valid_din) begin
                  channel_q <= pack_flit(tx_x_dest_din, tx_y_dest_din, tx_payload_din);
                  diff_q    <= ~diff_q;
                  timer_q   <= '0;
                  state_q   <= TX_WAIT_ACK;
               end
            end
            TX_WAIT_ACK: begin
               if (r2pe_ack_din) begin
                  state_q <= TX_IDLE;
               end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                  diff_q  <= ~diff_q;
                  timer_q <= '0;
                  if (retry_q != 8'hFF) begin
                     retry_q <= retry_q + 8'd1;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx_ready_dout       = (state_q == TX_IDLE);
   assign channel_dout        = channel_q;
   assign diff_pair_dout      = diff_q;
   assign tx_retry_count_dout = retry_q;

   // A new flit is a valid {t, ~t} encoding whose t differs from the last one.
   assign rx_new_c = (diff_pair_din[1] ^ diff_pair_din[0]) && (diff_pair_din[1] != t_rx_q);

   // Receive toggle tracker; updated even when the flit is dropped.
   always_ff @(posedge clka) begin
      if (rsta) begin
         t_rx_q <= 1'b0;
      end else if (rx_new_c) begin
         t_rx_q <= diff_pair_din[1];
      end
   end

   // Drop-on-full is decided inside the FIFO, so its full flag is not needed here.
   pe_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (PAYLOAD_W)
   ) u_rx_fifo (
      .clk      (clka),
      .rst      (rsta),
      .push     (rx_new_c),
      .pop      (rx_ready_din),
      .din      (channel_din),
      .head     (rx_payload_dout),
      .valid    (rx_valid_dout),
      .full     (rx_full_unused),
      .overflow (rx_overflow_dout)
   );

endmodule

// File: tb/tb_pe_network_interface.sv
// Self-checking bench for pe_network_interface (RX_DEPTH=4, ACK_TIMEOUT=4).
// Directed scenarios followed by randomized TX/RX traffic, compared against
// a queue-based receive model and an arithmetic retransmit model.
module tb_pe_network_interface;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 4;

   logic        clka = 1'b0;
   logic        rsta;
   logic        tx_valid_din;
   logic [3:0]  tx_x_dest_din;
   logic [3:0]  tx_y_dest_din;
   logic [39:0] tx_payload_din;
   logic        tx_ready_dout;
   logic [47:0] channel_dout;
   logic [1:0]  diff_pair_dout;
   logic        r2pe_ack_din;
   logic [39:0] channel_din;
   logic [1:0]  diff_pair_din;
   logic        rx_valid_dout;
   logic [39:0] rx_payload_dout;
   logic        rx_ready_din;
   logic        rx_overflow_dout;
   logic [7:0]  tx_retry_count_dout;

   always #5 clka = ~clka;

   pe_network_interface #(
      .RX_DEPTH    (DEPTH),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .clka                (clka),
      .rsta                (rsta),
      .tx_valid_din        (tx_valid_din),
      .tx_x_dest_din       (tx_x_dest_din),
      .tx_y_dest_din       (tx_y_dest_din),
      .tx_payload_din      (tx_payload_din),
      .tx_ready_dout       (tx_ready_dout),
      .channel_dout        (channel_dout),
      .diff_pair_dout      (diff_pair_dout),
      .r2pe_ack_din        (r2pe_ack_din),
      .channel_din         (channel_din),
      .diff_pair_din       (diff_pair_din),
      .rx_valid_dout       (rx_valid_dout),
      .rx_payload_dout     (rx_payload_dout),
      .rx_ready_din        (rx_ready_din),
      .rx_overflow_dout    (rx_overflow_dout),
      .tx_retry_count_dout (tx_retry_count_dout)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference state
   bit          t_tx_m;
   int          retry_m;
   logic [47:0] flit_m;
   bit          t_rx_m;
   bit          ovf_m;
   logic [39:0] q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   function automatic logic [1:0] enc(input bit t);
      return {t, ~t};
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"},   tx_ready_dout, 1'b1);
      chk({tag, "_channel"}, channel_dout, 48'h0);
      chk({tag, "_diff"},    diff_pair_dout, 2'b01);
      chk({tag, "_rxvalid"}, rx_valid_dout, 1'b0);
      chk({tag, "_rxhead"},  rx_payload_dout, 40'h0);
      chk({tag, "_ovf"},     rx_overflow_dout, 1'b0);
      chk({tag, "_retry"},   tx_retry_count_dout, 8'd0);
   endtask

   task automatic do_reset();
      rsta          = 1'b1;
      diff_pair_din = 2'b01;
      tx_valid_din  = 1'b0;
      r2pe_ack_din  = 1'b0;
      rx_ready_din  = 1'b0;
      step();
      rsta    = 1'b0;
      t_tx_m  = 1'b0;
      retry_m = 0;
      flit_m  = '0;
      t_rx_m  = 1'b0;
      ovf_m   = 1'b0;
      q.delete();
   endtask

   // Offer one packet while idle; it is accepted at the next edge.
   task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [39:0] p);
      tx_valid_din   = 1'b1;
      tx_x_dest_din  = x;
      tx_y_dest_din  = y;
      tx_payload_din = p;
      step();
      tx_valid_din = 1'b0;
      t_tx_m = ~t_tx_m;
      flit_m = {x, y, p};
      chk("tx_channel", channel_dout, flit_m);
      chk("tx_diff",    diff_pair_dout, enc(t_tx_m));
      chk("tx_busy",    tx_ready_dout, 1'b0);
   endtask

   // One receive cycle: kind 0 hold, 1 new toggle, 2 encoding 00, 3 encoding 11.
   task automatic rx_cycle(input int kind, input bit pop, input logic [39:0] data);
      bit pop_m;
      bit new_m;
      channel_din  = data;
      rx_ready_din = pop;
      case (kind)
         0:       diff_pair_din = enc(t_rx_m);
         1:       diff_pair_din = enc(~t_rx_m);
         2:       diff_pair_din = 2'b00;
         default: diff_pair_din = 2'b11;
      endcase
      pop_m = pop && (q.size() != 0);
      new_m = (kind == 1);
      step();
      rx_ready_din = 1'b0;
      if (pop_m) void'(q.pop_front());
      if (new_m) begin
         t_rx_m = ~t_rx_m;
         if (q.size() < DEPTH) q.push_back(data);
         else ovf_m = 1'b1;
      end
      chk("rx_valid", rx_valid_dout, (q.size() != 0));
      if (q.size() != 0) chk("rx_head", rx_payload_dout, q[0]);
      chk("rx_ovf", rx_overflow_dout, ovf_m);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tx_x_dest_din  = '0;
      tx_y_dest_din  = '0;
      tx_payload_din = '0;
      channel_din    = '0;

      // Reset state
      do_reset();
      step();
      check_reset_values("reset");

      // Single packet, ack two cycles after acceptance
      send(4'd3, 4'd1, 40'h12_3456_789A);
      chk("single_flit", channel_dout, 48'h3112_3456_789A);
      chk("single_diff", diff_pair_dout, 2'b10);
      step();
      r2pe_ack_din = 1'b1;
      step();
      r2pe_ack_din = 1'b0;
      chk("single_ready", tx_ready_dout, 1'b1);
      chk("single_diff_hold", diff_pair_dout, 2'b10);
      chk("single_retry", tx_retry_count_dout, 8'd0);

      // No ack: a toggle every TMO cycles, three expiries
      send(4'd5, 4'd9, 40'hAB_CDEF_0123);
      for (int k = 1; k <= 3; k++) begin
         for (int c = 1; c <= TMO; c++) begin
            step();
            if (c == TMO) begin
               t_tx_m = ~t_tx_m;
               retry_m++;
            end
            chk("noack_diff", diff_pair_dout, enc(t_tx_m));
            chk("noack_retry", tx_retry_count_dout, 8'(retry_m));
         end
      end
      chk("noack_retry3", tx_retry_count_dout, 8'd3);
      // Ack coincident with the fourth expiry
      for (int c = 1; c < TMO; c++) step();
      r2pe_ack_din = 1'b1;
      step();
      r2pe_ack_din = 1'b0;
      chk("coinc_ready", tx_ready_dout, 1'b1);
      chk("coinc_diff", diff_pair_dout, enc(t_tx_m));
      chk("coinc_retry", tx_retry_count_dout, 8'd3);
      step();
      step();
      chk("coinc_diff_later", diff_pair_dout, enc(t_tx_m));
      chk("coinc_flit_hold", channel_dout, flit_m);

      // RX burst of five with no pops: fifth dropped
      for (int i = 1; i <= 5; i++) rx_cycle(1, 1'b0, 40'(i));
      chk("burst_ovf", rx_overflow_dout, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         chk("burst_pop_head", rx_payload_dout, 40'(i));
         rx_cycle(0, 1'b1, 40'h0);
      end
      chk("burst_empty", rx_valid_dout, 1'b0);

      // Invalid encodings push nothing; 10 then pushes once
      do_reset();
      chk("reset2_ovf", rx_overflow_dout, 1'b0);
      rx_cycle(3, 1'b0, 40'hDEAD);
      rx_cycle(2, 1'b0, 40'hBEEF);
      chk("invalid_nopush", rx_valid_dout, 1'b0);
      rx_cycle(1, 1'b0, 40'h77_0000_0077);
      chk("enc10_din", diff_pair_din, 2'b10);
      chk("enc10_push", rx_payload_dout, 40'h77_0000_0077);
      rx_cycle(0, 1'b0, 40'h1);
      rx_cycle(0, 1'b1, 40'h2);
      chk("enc10_single", rx_valid_dout, 1'b0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) rx_cycle(1, 1'b0, 40'({$urandom(), $urandom()}));
      rx_cycle(1, 1'b1, 40'h55_AAAA_5555);
      chk("fullpop_ovf", rx_overflow_dout, 1'b0);
      chk("fullpop_occ", q.size(), DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         chk("fullpop_valid", rx_valid_dout, 1'b1);
         rx_cycle(0, 1'b1, 40'h0);
      end
      chk("fullpop_drained", rx_valid_dout, 1'b0);

      // Randomized receive traffic
      for (int i = 0; i < 150; i++)
         rx_cycle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  40'({$urandom(), $urandom()}));

      // Randomized transmit traffic with random ack delays and idle gaps
      for (int pk = 0; pk < 12; pk++) begin
         int gap;
         int d;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            r2pe_ack_din = 1'($urandom_range(0, 1));
            step();
            r2pe_ack_din = 1'b0;
            chk("idle_ready", tx_ready_dout, 1'b1);
            chk("idle_diff", diff_pair_dout, enc(t_tx_m));
         end
         send(4'($urandom), 4'($urandom), 40'({$urandom(), $urandom()}));
         d = int'($urandom_range(1, 10));
         for (int j = 1; j < d; j++) begin
            tx_valid_din   = 1'($urandom_range(0, 1));
            tx_payload_din = 40'({$urandom(), $urandom()});
            step();
            if ((j % TMO) == 0) begin
               t_tx_m = ~t_tx_m;
               if (retry_m < 255) retry_m++;
            end
            chk("rand_wait_diff", diff_pair_dout, enc(t_tx_m));
            chk("rand_wait_flit", channel_dout, flit_m);
            chk("rand_wait_busy", tx_ready_dout, 1'b0);
         end
         tx_valid_din = 1'b0;
         r2pe_ack_din = 1'b1;
         step();
         r2pe_ack_din = 1'b0;
         chk("rand_ack_ready", tx_ready_dout, 1'b1);
         chk("rand_ack_diff", diff_pair_dout, enc(t_tx_m));
         chk("rand_retry", tx_retry_count_dout, 8'(retry_m));
      end

      // Retry counter saturation
      send(4'd2, 4'd7, 40'h01_0203_0405);
      for (int j = 1; j <= 260 * TMO; j++) begin
         step();
         if ((j % TMO) == 0) begin
            t_tx_m = ~t_tx_m;
            if (retry_m < 255) retry_m++;
         end
      end
      chk("sat_retry", tx_retry_count_dout, 8'd255);
      chk("sat_diff", diff_pair_dout, enc(t_tx_m));
      r2pe_ack_din = 1'b1;
      step();
      r2pe_ack_din = 1'b0;
      chk("sat_ack_ready", tx_ready_dout, 1'b1);

      // Reset during WAIT_ACK with two entries queued
      send(4'd9, 4'd4, 40'hFE_DCBA_9876);
      rx_cycle(1, 1'b0, 40'h11);
      rx_cycle(1, 1'b0, 40'h22);
      chk("midrst_pre_busy", tx_ready_dout, 1'b0);
      do_reset();
      check_reset_values("midrst");
      r2pe_ack_din = 1'b1;
      step();
      r2pe_ack_din = 1'b0;
      check_reset_values("midrst_ack");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
